control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the single-bus RISC `Datapath`.
- Replaces the hand-written testbench FSM.
- Runs the 3-step fetch (T0–T2), decodes the `ir` opcode and issues the per-class execute steps (T3–T7); one step per clock.
- Drives every `Datapath` strobe, consumes `ir` and `con_out`, and halts on `halt` or an external `stop`.

Parameters:
- IR_W, 32, instruction register width
- OP_MSB, 31, MSB of the 5-bit opcode field (`ir[OP_MSB -: 5]`)

Ports:
- clk  in  1  system clock
- clr  in  1  reset; one clock, synchronous and active-high
- ir  in  IR_W  `Datapath` IR output, stable from T3 onward
- con_out  in  1  branch condition flag, valid the cycle after a `con_enable` step
- stop  in  1  halt request, honoured at an instruction boundary
- run  out  1  high unless in HALT or RESET
- pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out  out  1 each  bus drivers
- mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable, hi_enable, lo_enable, outport_enable, con_enable  out  1 each  register loads
- read, ram_write  out  1 each  memory strobes
- pc_increment, alu_add  out  1 each  ALU overrides (+1 / force ADD)
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register-file select/strobe

Behaviour:
- **States:** RESET, F0, F1, F2, E3, E4, E5, E6, E7, HALT.
- **Outputs:** pure combinational decode of (state, opcode class). Every strobe not listed for a step is 0.
- **Reset:** `clr`=1 at a posedge sends the FSM to RESET from any state, including mid-instruction. In RESET all outputs are 0 and `run`=0. The next step is F0.
- **Fetch (all instructions):**
  - F0: `pc_out mar_enable pc_increment z_enable`
  - F1: `zlo_out pc_enable read mdr_enable`
  - F2: `mdr_out ir_enable`
  - Then E3.
- **Opcode classes and execute steps** (Mini SRC encoding):
  - ld 00000: E3 `grb ba_out y_enable`; E4 `c_sign_extended_out alu_add z_enable`; E5 `zlo_out mar_enable`; E6 `read mdr_enable`; E7 `mdr_out gra r_in`.
  - ldi 00001: E3, E4 as ld; E5 `zlo_out gra r_in`.
  - st 00010: E3–E5 as ld; E6 `gra r_out mdr_enable` (`read`=0); E7 `ram_write`.
  - ALU R-type 00011–01010: E3 `grb r_out y_enable`; E4 `grc r_out z_enable`; E5 `zlo_out gra r_in`.
  - ALU imm 01011–01101: E3 `grb r_out y_enable`; E4 `c_sign_extended_out z_enable`; E5 `zlo_out gra r_in`.
  - mul/div 01110–01111: E3 `gra r_out y_enable`; E4 `grb r_out z_enable`; E5 `zlo_out lo_enable`; E6 `zhi_out hi_enable`.
  - neg/not 10000–10001: E3 `grb r_out z_enable`; E4 `zlo_out gra r_in`.
  - br 10010: E3 `gra r_out con_enable`; E4 `pc_out y_enable`; E5 `c_sign_extended_out alu_add z_enable`; E6 `zlo_out pc_enable` gated by `con_out`.
    - Branch target = PC+1+C; there is no extra increment.
    - With `con_out`=0, E6 asserts nothing and the instruction still spends E6.
  - jr 10011: E3 `gra r_out pc_enable`.
  - in 10101: E3 `inport_out gra r_in`.
  - out 10110: E3 `gra r_out outport_enable`.
  - mfhi 10111: E3 `hi_out gra r_in`.
  - mflo 11000: E3 `lo_out gra r_in`.
  - nop 11001, jal 10100 and undefined opcodes: no E steps.
  - halt 11010: no E steps.
- **Boundary:** the last step of a class is F2 for nop, halt and undefined opcodes, otherwise its final E step.
  - halt opcode, or `stop`=1 sampled at that last step's posedge → HALT; otherwise → F0.
- **HALT:** all strobes 0, `run`=0. Held until `clr`. `stop` is ignored mid-instruction.

Decomposition:
- `risc_ctrl_pkg`:
  - opcode localparams (`OP_LD` … `OP_HALT`)
  - state enum
  - opcode-class enum (`CL_LD`, `CL_LDI`, `CL_ST`, `CL_ALU3`, `CL_ALUI`, `CL_MULDIV`, `CL_UNARY`, `CL_BR`, `CL_JR`, `CL_IN`, `CL_OUT`, `CL_MFHI`, `CL_MFLO`, `CL_NOP`, `CL_HALT`)
- Sub-module `ctrl_decode`: combinational opcode → class plus last-step index. The `control_unit` keeps the state register and the output decode.

Test Plan:
- **Reset:** `clr`=1 for 2 cycles mid-E4 of ld → cycle after the edge: all strobes 0, `run`=0; then F0 with `pc_out`=`mar_enable`=`pc_increment`=`z_enable`=1.
- **ldi:** `ir`=0x08800005 (ldi r1,5) → E3 `grb`/`ba_out`/`y_enable`; E4 `c_sign_extended_out`+`alu_add`; E5 `zlo_out gra r_in`; F0 on the next cycle (6 cycles total).
- **Branch:** `ir`=0x91000003 (brzr r2,3):
  - `con_out`=1 → E6 `zlo_out`+`pc_enable`=1, 7 cycles.
  - `con_out`=0 → E6 all 0, then F0.
- **ALU:** `ir`=0x19890000 (add r3,r1,r2) → E4 `grc r_out z_enable`; E5 `r_in`; no `hi_enable`/`lo_enable`.
- **st:** E6 `mdr_enable`=1 with `read`=0; E7 `ram_write`=1 for exactly 1 cycle.
- **Halt/stop:**
  - `ir`=0xD0000000 → HALT after F2, `run`=0, held 20 cycles.
  - `stop`=1 asserted in E4 of add → completes E5, then HALT.
  - `clr` releases HALT → RESET → F0.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared types for the single-bus RISC control sequencer: opcodes, FSM states,
// opcode classes and the datapath strobe bundle.
package risc_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_RESET, ST_F0, ST_F1, ST_F2, ST_E3, ST_E4, ST_E5, ST_E6, ST_E7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU3, CL_ALUI, CL_MULDIV, CL_UNARY, CL_BR,
    CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } cls_t;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic hi_out;
    logic lo_out;
    logic mdr_out;
    logic inport_out;
    logic c_sign_extended_out;
    logic mar_enable;
    logic z_enable;
    logic y_enable;
    logic pc_enable;
    logic mdr_enable;
    logic ir_enable;
    logic hi_enable;
    logic lo_enable;
    logic outport_enable;
    logic con_enable;
    logic read;
    logic ram_write;
    logic pc_increment;
    logic alu_add;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
  } strobe_t;

  // Step index of a fetch/execute state (T0..T7); RESET/HALT never reach the compare.
  function automatic logic [2:0] step_of(input state_t s);
    case (s)
      ST_F1:   return 3'd1;
      ST_F2:   return 3'd2;
      ST_E3:   return 3'd3;
      ST_E4:   return 3'd4;
      ST_E5:   return 3'd5;
      ST_E6:   return 3'd6;
      ST_E7:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t next_step(input state_t s);
    case (s)
      ST_F2:   return ST_E3;
      ST_E3:   return ST_E4;
      ST_E4:   return ST_E5;
      ST_E5:   return ST_E6;
      ST_E6:   return ST_E7;
      default: return ST_F0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> Datapath bundle: IR and condition flag in, every strobe out.
interface control_unit_if #(
  parameter int IR_W = 32
);
  logic [IR_W-1:0] ir;
  logic            con_out;

  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out;
  logic c_sign_extended_out;
  logic mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable;
  logic hi_enable, lo_enable, outport_enable, con_enable;
  logic read, ram_write, pc_increment, alu_add;
  logic gra, grb, grc, r_in, r_out, ba_out;

  modport master (
    input  ir, con_out,
    output pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
           c_sign_extended_out,
           mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable,
           hi_enable, lo_enable, outport_enable, con_enable,
           read, ram_write, pc_increment, alu_add,
           gra, grb, grc, r_in, r_out, ba_out
  );

  modport slave (
    output ir, con_out,
    input  pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
           c_sign_extended_out,
           mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable,
           hi_enable, lo_enable, outport_enable, con_enable,
           read, ram_write, pc_increment, alu_add,
           gra, grb, grc, r_in, r_out, ba_out
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode -> instruction class and index of the class's final step (2 = F2 .. 7 = E7).
module ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output cls_t       cls_o,
  output logic [2:0] last_step_o
);

  always_comb begin
    cls_o = CL_NOP;
    case (opcode_i)
      OP_LD:   cls_o = CL_LD;
      OP_LDI:  cls_o = CL_LDI;
      OP_ST:   cls_o = CL_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
               cls_o = CL_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:
               cls_o = CL_ALUI;
      OP_MUL, OP_DIV:
               cls_o = CL_MULDIV;
      OP_NEG, OP_NOT:
               cls_o = CL_UNARY;
      OP_BR:   cls_o = CL_BR;
      OP_JR:   cls_o = CL_JR;
      OP_IN:   cls_o = CL_IN;
      OP_OUT:  cls_o = CL_OUT;
      OP_MFHI: cls_o = CL_MFHI;
      OP_MFLO: cls_o = CL_MFLO;
      OP_HALT: cls_o = CL_HALT;
      OP_JAL, OP_NOP: cls_o = CL_NOP;
      default: cls_o = CL_NOP;
    endcase
  end

  always_comb begin
    last_step_o = 3'd2;
    case (cls_o)
      CL_LD, CL_ST:                       last_step_o = 3'd7;
      CL_MULDIV, CL_BR:                   last_step_o = 3'd6;
      CL_LDI, CL_ALU3, CL_ALUI:           last_step_o = 3'd5;
      CL_UNARY:                           last_step_o = 3'd4;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: last_step_o = 3'd3;
      default:                            last_step_o = 3'd2;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus RISC datapath: 3-step fetch,
// per-class execute steps, halt on the halt opcode or on stop at an instruction boundary.
module control_unit
  import risc_ctrl_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int OP_MSB = 31
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stop,
  output logic          run,
  control_unit_if.master bus
);

  state_t     state_q, state_d;
  cls_t       cls;
  logic [2:0] last_step;
  logic [4:0] opcode;
  strobe_t    s;

  assign opcode = bus.ir[OP_MSB -: 5];

  ctrl_decode u_decode (
    .opcode_i    (opcode),
    .cls_o       (cls),
    .last_step_o (last_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_F0;
      ST_F0:    state_d = ST_F1;
      ST_F1:    state_d = ST_F2;
      ST_HALT:  state_d = ST_HALT;
      default: begin
        // F2..E7: stop and the halt opcode only take effect on the class's last step
        if (step_of(state_q) == last_step)
          state_d = (cls == CL_HALT || stop) ? ST_HALT : ST_F0;
        else
          state_d = next_step(state_q);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  assign run = (state_q != ST_RESET) && (state_q != ST_HALT);

  always_comb begin
    s = '0;
    case (state_q)
      ST_F0: begin s.pc_out = 1'b1; s.mar_enable = 1'b1; s.pc_increment = 1'b1; s.z_enable = 1'b1; end
      ST_F1: begin s.zlo_out = 1'b1; s.pc_enable = 1'b1; s.read = 1'b1; s.mdr_enable = 1'b1; end
      ST_F2: begin s.mdr_out = 1'b1; s.ir_enable = 1'b1; end
      ST_E3: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_enable = 1'b1; end
          CL_ALU3, CL_ALUI:     begin s.grb = 1'b1; s.r_out = 1'b1; s.y_enable = 1'b1; end
          CL_MULDIV:            begin s.gra = 1'b1; s.r_out = 1'b1; s.y_enable = 1'b1; end
          CL_UNARY:             begin s.grb = 1'b1; s.r_out = 1'b1; s.z_enable = 1'b1; end
          CL_BR:                begin s.gra = 1'b1; s.r_out = 1'b1; s.con_enable = 1'b1; end
          CL_JR:                begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_enable = 1'b1; end
          CL_IN:                begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CL_OUT:               begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_enable = 1'b1; end
          CL_MFHI:              begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CL_MFLO:              begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          default: ;
        endcase
      end
      ST_E4: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin s.c_sign_extended_out = 1'b1; s.alu_add = 1'b1; s.z_enable = 1'b1; end
          CL_ALU3:              begin s.grc = 1'b1; s.r_out = 1'b1; s.z_enable = 1'b1; end
          CL_ALUI:              begin s.c_sign_extended_out = 1'b1; s.z_enable = 1'b1; end
          CL_MULDIV:            begin s.grb = 1'b1; s.r_out = 1'b1; s.z_enable = 1'b1; end
          CL_UNARY:             begin s.zlo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CL_BR:                begin s.pc_out = 1'b1; s.y_enable = 1'b1; end
          default: ;
        endcase
      end
      ST_E5: begin
        case (cls)
          CL_LD, CL_ST:              begin s.zlo_out = 1'b1; s.mar_enable = 1'b1; end
          CL_LDI, CL_ALU3, CL_ALUI:  begin s.zlo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CL_MULDIV:                 begin s.zlo_out = 1'b1; s.lo_enable = 1'b1; end
          CL_BR:                     begin s.c_sign_extended_out = 1'b1; s.alu_add = 1'b1; s.z_enable = 1'b1; end
          default: ;
        endcase
      end
      ST_E6: begin
        case (cls)
          CL_LD:     begin s.read = 1'b1; s.mdr_enable = 1'b1; end
          CL_ST:     begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_enable = 1'b1; end
          CL_MULDIV: begin s.zhi_out = 1'b1; s.hi_enable = 1'b1; end
          CL_BR:     begin s.zlo_out = bus.con_out; s.pc_enable = bus.con_out; end
          default: ;
        endcase
      end
      ST_E7: begin
        case (cls)
          CL_LD:   begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CL_ST:   s.ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.pc_out              = s.pc_out;
  assign bus.zlo_out             = s.zlo_out;
  assign bus.zhi_out             = s.zhi_out;
  assign bus.hi_out              = s.hi_out;
  assign bus.lo_out              = s.lo_out;
  assign bus.mdr_out             = s.mdr_out;
  assign bus.inport_out          = s.inport_out;
  assign bus.c_sign_extended_out = s.c_sign_extended_out;
  assign bus.mar_enable          = s.mar_enable;
  assign bus.z_enable            = s.z_enable;
  assign bus.y_enable            = s.y_enable;
  assign bus.pc_enable           = s.pc_enable;
  assign bus.mdr_enable          = s.mdr_enable;
  assign bus.ir_enable           = s.ir_enable;
  assign bus.hi_enable           = s.hi_enable;
  assign bus.lo_enable           = s.lo_enable;
  assign bus.outport_enable      = s.outport_enable;
  assign bus.con_enable          = s.con_enable;
  assign bus.read                = s.read;
  assign bus.ram_write           = s.ram_write;
  assign bus.pc_increment        = s.pc_increment;
  assign bus.alu_add             = s.alu_add;
  assign bus.gra                 = s.gra;
  assign bus.grb                 = s.grb;
  assign bus.grc                 = s.grc;
  assign bus.r_in                = s.r_in;
  assign bus.r_out               = s.r_out;
  assign bus.ba_out              = s.ba_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed checks of the control sequencer: every step's full strobe vector plus run.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr, stop, run;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  control_unit_if #(.IR_W(32)) bus ();

  control_unit #(.IR_W(32), .OP_MSB(31)) dut (
    .clk  (clk),
    .clr  (clr),
    .stop (stop),
    .run  (run),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [28:0] RUN  = 29'd1 << 28;
  localparam logic [28:0] PCO  = 29'd1 << 27;
  localparam logic [28:0] ZLO  = 29'd1 << 26;
  localparam logic [28:0] ZHI  = 29'd1 << 25;
  localparam logic [28:0] HIO  = 29'd1 << 24;
  localparam logic [28:0] LOO  = 29'd1 << 23;
  localparam logic [28:0] MDRO = 29'd1 << 22;
  localparam logic [28:0] INP  = 29'd1 << 21;
  localparam logic [28:0] CSX  = 29'd1 << 20;
  localparam logic [28:0] MARE = 29'd1 << 19;
  localparam logic [28:0] ZE   = 29'd1 << 18;
  localparam logic [28:0] YE   = 29'd1 << 17;
  localparam logic [28:0] PCE  = 29'd1 << 16;
  localparam logic [28:0] MDRE = 29'd1 << 15;
  localparam logic [28:0] IRE  = 29'd1 << 14;
  localparam logic [28:0] HIE  = 29'd1 << 13;
  localparam logic [28:0] LOE  = 29'd1 << 12;
  localparam logic [28:0] OUTE = 29'd1 << 11;
  localparam logic [28:0] CONE = 29'd1 << 10;
  localparam logic [28:0] RD   = 29'd1 << 9;
  localparam logic [28:0] WR   = 29'd1 << 8;
  localparam logic [28:0] PCI  = 29'd1 << 7;
  localparam logic [28:0] ADD  = 29'd1 << 6;
  localparam logic [28:0] GRA  = 29'd1 << 5;
  localparam logic [28:0] GRB  = 29'd1 << 4;
  localparam logic [28:0] GRC  = 29'd1 << 3;
  localparam logic [28:0] RIN  = 29'd1 << 2;
  localparam logic [28:0] ROUT = 29'd1 << 1;
  localparam logic [28:0] BAO  = 29'd1 << 0;

  localparam logic [28:0] F0E = RUN | PCO | MARE | PCI | ZE;
  localparam logic [28:0] F1E = RUN | ZLO | PCE | RD | MDRE;
  localparam logic [28:0] F2E = RUN | MDRO | IRE;

  logic [28:0] obs;
  assign obs = {run, bus.pc_out, bus.zlo_out, bus.zhi_out, bus.hi_out, bus.lo_out,
                bus.mdr_out, bus.inport_out, bus.c_sign_extended_out, bus.mar_enable,
                bus.z_enable, bus.y_enable, bus.pc_enable, bus.mdr_enable, bus.ir_enable,
                bus.hi_enable, bus.lo_enable, bus.outport_enable, bus.con_enable,
                bus.read, bus.ram_write, bus.pc_increment, bus.alu_add,
                bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out};

  task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare the step's outputs.
  task automatic cyc(input string tag, input logic [28:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
  endtask

  // ir changes only after F0 is observed, so the previous boundary decode is undisturbed.
  task automatic fetch(input string name, input logic [31:0] instr);
    cyc({name, "_F0"}, F0E);
    bus.ir = instr;
    cyc({name, "_F1"}, F1E);
    cyc({name, "_F2"}, F2E);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    stop = 1'b0;
    bus.ir = '0;
    bus.con_out = 1'b0;
    cyc("reset0", '0);
    cyc("reset1", '0);
    clr = 1'b0;

    // ld interrupted by a two-cycle clr in E4
    fetch("ldint", 32'h0080_0004);
    cyc("ldint_E3", RUN | GRB | BAO | YE);
    cyc("ldint_E4", RUN | CSX | ADD | ZE);
    clr = 1'b1;
    cyc("ldint_rst0", '0);
    cyc("ldint_rst1", '0);
    clr = 1'b0;

    fetch("ldi", 32'h0880_0005);
    cyc("ldi_E3", RUN | GRB | BAO | YE);
    cyc("ldi_E4", RUN | CSX | ADD | ZE);
    cyc("ldi_E5", RUN | ZLO | GRA | RIN);

    fetch("ld", 32'h0080_0004);
    cyc("ld_E3", RUN | GRB | BAO | YE);
    cyc("ld_E4", RUN | CSX | ADD | ZE);
    cyc("ld_E5", RUN | ZLO | MARE);
    cyc("ld_E6", RUN | RD | MDRE);
    cyc("ld_E7", RUN | MDRO | GRA | RIN);

    bus.con_out = 1'b1;
    fetch("brT", 32'h9100_0003);
    cyc("brT_E3", RUN | GRA | ROUT | CONE);
    cyc("brT_E4", RUN | PCO | YE);
    cyc("brT_E5", RUN | CSX | ADD | ZE);
    cyc("brT_E6", RUN | ZLO | PCE);

    fetch("brF", 32'h9100_0003);
    bus.con_out = 1'b0;
    cyc("brF_E3", RUN | GRA | ROUT | CONE);
    cyc("brF_E4", RUN | PCO | YE);
    cyc("brF_E5", RUN | CSX | ADD | ZE);
    cyc("brF_E6", RUN);

    fetch("add", 32'h1989_0000);
    cyc("add_E3", RUN | GRB | ROUT | YE);
    cyc("add_E4", RUN | GRC | ROUT | ZE);
    cyc("add_E5", RUN | ZLO | GRA | RIN);

    fetch("st", 32'h1080_0002);
    cyc("st_E3", RUN | GRB | BAO | YE);
    cyc("st_E4", RUN | CSX | ADD | ZE);
    cyc("st_E5", RUN | ZLO | MARE);
    cyc("st_E6", RUN | GRA | ROUT | MDRE);
    cyc("st_E7", RUN | WR);

    fetch("mul", 32'h7000_0000);
    cyc("mul_E3", RUN | GRA | ROUT | YE);
    cyc("mul_E4", RUN | GRB | ROUT | ZE);
    cyc("mul_E5", RUN | ZLO | LOE);
    cyc("mul_E6", RUN | ZHI | HIE);

    fetch("neg", 32'h8000_0000);
    cyc("neg_E3", RUN | GRB | ROUT | ZE);
    cyc("neg_E4", RUN | ZLO | GRA | RIN);

    fetch("addi", 32'h5800_0000);
    cyc("addi_E3", RUN | GRB | ROUT | YE);
    cyc("addi_E4", RUN | CSX | ZE);
    cyc("addi_E5", RUN | ZLO | GRA | RIN);

    fetch("jr", 32'h9800_0000);
    cyc("jr_E3", RUN | GRA | ROUT | PCE);
    fetch("in", 32'hA800_0000);
    cyc("in_E3", RUN | INP | GRA | RIN);
    fetch("out", 32'hB000_0000);
    cyc("out_E3", RUN | GRA | ROUT | OUTE);
    fetch("mfhi", 32'hB800_0000);
    cyc("mfhi_E3", RUN | HIO | GRA | RIN);
    fetch("mflo", 32'hC000_0000);
    cyc("mflo_E3", RUN | LOO | GRA | RIN);
    fetch("nop", 32'hC800_0000);
    fetch("jal", 32'hA000_0000);
    fetch("undef", 32'hF800_0000);

    // stop raised mid-instruction is honoured only at the boundary after E5
    fetch("addstop", 32'h1989_0000);
    cyc("addstop_E3", RUN | GRB | ROUT | YE);
    cyc("addstop_E4", RUN | GRC | ROUT | ZE);
    stop = 1'b1;
    cyc("addstop_E5", RUN | ZLO | GRA | RIN);
    cyc("addstop_halt", '0);
    stop = 1'b0;
    cyc("addstop_hold", '0);
    clr = 1'b1;
    cyc("addstop_rst", '0);
    clr = 1'b0;

    fetch("halt", 32'hD000_0000);
    for (int i = 0; i < 20; i++) cyc("halt_hold", '0);
    clr = 1'b1;
    cyc("halt_rst", '0);
    clr = 1'b0;
    cyc("halt_F0", F0E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
